// File: rtl/fifosync_flags_if.sv
// Port bundle for the single-clock FIFO: write side, read side and status flags.
// The design drives it through the slave modport and the user through the master modport.
interface fifosync_flags_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    // Handshake: a write transfers on a rising edge where wr_en=1 and full=0.
    // A read/pop transfers on a rising edge where rd_en=1 and empty=0.
    // With a registered read, rd_valid marks the single cycle that holds the word read.
    // With fall-through, rd_valid=1 means rd_data already shows the head word.
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          almost_empty;
    logic          underflow;
    logic [AW:0]   count;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, almost_full, overflow,
        input  rd_data, rd_valid, empty, almost_empty, underflow, count
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, almost_full, overflow,
        output rd_data, rd_valid, empty, almost_empty, underflow, count
    );
endinterface

// File: rtl/fifosync_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error flags,
// synchronous flush and a choice of registered or first-word-fall-through read.
module fifosync_flags #(
    parameter int DW       = 32,
    parameter int AW       = 6,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = (1 << AW) - 2,
    parameter int AE_LEVEL = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             clear,
    fifosync_flags_if.slave fifo
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_V    = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AE_V    = (AW + 1)'(AE_LEVEL);

    if (DW < 1) begin : g_chk_dw
        $error("fifosync_flags: DW must be >= 1");
    end
    if (AW < 1) begin : g_chk_aw
        $error("fifosync_flags: AW must be >= 1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_chk_fwft
        $error("fifosync_flags: FWFT must be 0 or 1");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_chk_af
        $error("fifosync_flags: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_chk_ae
        $error("fifosync_flags: AE_LEVEL must be in 0..DEPTH-1");
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count_w;
    logic          full_w;
    logic          empty_w;
    logic          wr_acc;
    logic          rd_acc;
    logic          overflow_q;
    logic          underflow_q;

    // Pointers carry one extra wrap bit so full and empty differ without a separate flag.
    assign count_w = wr_ptr - rd_ptr;
    assign full_w  = (count_w == DEPTH_V);
    assign empty_w = (count_w == '0);

    // Acceptance looks only at start-of-cycle state; flush suppresses both sides.
    assign wr_acc = fifo.wr_en && !full_w && !clear;
    assign rd_acc = fifo.rd_en && !empty_w && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fifo.wr_en && full_w) begin
                overflow_q <= 1'b1;
            end
            if (fifo.rd_en && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Storage has no reset; stale words are unreachable once the pointers move.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= fifo.wr_data;
        end
    end

    if (FWFT == 0) begin : g_reg_read
        logic [DW-1:0] rd_data_q;
        logic          rd_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (clear) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem[rd_ptr[AW-1:0]];
                end
            end
        end

        assign fifo.rd_data  = rd_data_q;
        assign fifo.rd_valid = rd_valid_q;
    end else begin : g_fwft_read
        // Head word is presented directly; rd_en only advances past it.
        assign fifo.rd_data  = mem[rd_ptr[AW-1:0]];
        assign fifo.rd_valid = !empty_w;
    end

    assign fifo.count        = count_w;
    assign fifo.full         = full_w;
    assign fifo.empty        = empty_w;
    assign fifo.almost_full  = (count_w >= AF_V);
    assign fifo.almost_empty = (count_w <= AE_V);
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;
endmodule

// File: tb/tb_fifosync_flags.sv
// Bench for fifosync_flags: a registered-read and a fall-through instance share stimulus
// and are each checked against a queue model of the FIFO after every clock edge.
module tb_fifosync_flags;
  localparam int DW = 8;
  localparam int AW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  fifosync_flags_if #(.DW(DW), .AW(AW)) if0 ();
  fifosync_flags_if #(.DW(DW), .AW(AW)) if1 ();

  fifosync_flags #(.DW(DW), .AW(AW), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fifo(if0)
  );
  fifosync_flags #(.DW(DW), .AW(AW), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .fifo(if1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  logic ovf0, unf0, rv0, ovf1, unf1;
  logic [DW-1:0] rdata0;

  // Status layout: {count, full, almost_full, empty, almost_empty, overflow, underflow, rd_valid, rd_data}
  function automatic logic [17:0] exp0();
    int n = exp_q0.size();
    return {3'(n), n == 4, n >= 2, n == 0, n <= 2, ovf0, unf0, rv0, rdata0};
  endfunction

  function automatic logic [17:0] obs0();
    return {if0.count, if0.full, if0.almost_full, if0.empty, if0.almost_empty,
            if0.overflow, if0.underflow, if0.rd_valid, if0.rd_data};
  endfunction

  // Fall-through rd_data only means something while a word is present.
  function automatic logic [17:0] exp1();
    int n = exp_q1.size();
    logic [DW-1:0] head = (n != 0) ? exp_q1[0] : 8'h00;
    return {3'(n), n == 4, n >= 2, n == 0, n <= 2, ovf1, unf1, n != 0, head};
  endfunction

  function automatic logic [17:0] obs1();
    return {if1.count, if1.full, if1.almost_full, if1.empty, if1.almost_empty,
            if1.overflow, if1.underflow, if1.rd_valid, (if1.rd_valid ? if1.rd_data : 8'h00)};
  endfunction

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    ovf0 = 1'b0; unf0 = 1'b0; rv0 = 1'b0; rdata0 = 8'h00;
    ovf1 = 1'b0; unf1 = 1'b0;
  endtask

  task automatic model_edge(input logic wr, input logic [DW-1:0] wd, input logic rd,
                            input logic clr);
    bit full0 = (exp_q0.size() == 4);
    bit empty0 = (exp_q0.size() == 0);
    bit full1 = (exp_q1.size() == 4);
    bit empty1 = (exp_q1.size() == 0);
    if (clr) begin
      exp_q0.delete(); exp_q1.delete();
      ovf0 = 1'b0; unf0 = 1'b0; rv0 = 1'b0;
      ovf1 = 1'b0; unf1 = 1'b0;
    end else begin
      if (wr && full0) ovf0 = 1'b1;
      if (rd && empty0) unf0 = 1'b1;
      rv0 = 1'b0;
      if (rd && !empty0) begin
        rdata0 = exp_q0.pop_front();
        rv0 = 1'b1;
      end
      if (wr && !full0) exp_q0.push_back(wd);
      if (wr && full1) ovf1 = 1'b1;
      if (rd && empty1) unf1 = 1'b1;
      if (rd && !empty1) void'(exp_q1.pop_front());
      if (wr && !full1) exp_q1.push_back(wd);
    end
  endtask

  // ---------------- driver ----------------
  // Drives both instances for one cycle; returns 1 time unit after the edge.
  task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rd, input logic clr);
    if0.wr_en = wr; if0.wr_data = wd; if0.rd_en = rd;
    if1.wr_en = wr; if1.wr_data = wd; if1.rd_en = rd;
    clear = clr;
    @(posedge clk);
    model_edge(wr, wd, rd, clr);
    #1;
    if0.wr_en = 1'b0; if0.rd_en = 1'b0;
    if1.wr_en = 1'b0; if1.rd_en = 1'b0;
    clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    model_reset();
    if (obs0() !== exp0()) begin
      n_err++; $display("FAIL reset_ff0: got %h expected %h", obs0(), exp0());
    end
    n_cmp++;
    if (obs1() !== exp1()) begin
      n_err++; $display("FAIL reset_ff1: got %h expected %h", obs1(), exp1());
    end
    n_cmp++;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
      if (obs0() !== exp0()) begin
        n_err++; $display("FAIL fill_ff0[%0d]: got %h expected %h", i, obs0(), exp0());
      end
      n_cmp++;
      if (obs1() !== exp1()) begin
        n_err++; $display("FAIL fill_ff1[%0d]: got %h expected %h", i, obs1(), exp1());
      end
      n_cmp++;
    end
    if (if0.count !== 3'd4 || if0.full !== 1'b1 || if0.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL fill_final: count=%0d full=%b ovf=%b, expected 4 1 1",
               if0.count, if0.full, if0.overflow);
    end
    n_cmp++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      if (obs0() !== exp0()) begin
        n_err++; $display("FAIL drain_ff0[%0d]: got %h expected %h", i, obs0(), exp0());
      end
      n_cmp++;
      if (obs1() !== exp1()) begin
        n_err++; $display("FAIL drain_ff1[%0d]: got %h expected %h", i, obs1(), exp1());
      end
      n_cmp++;
      if (i < 4 && (if0.rd_valid !== 1'b1 || if0.rd_data !== 8'(8'h11 * (i + 1)))) begin
        n_err++;
        $display("FAIL drain_word[%0d]: rd_valid=%b rd_data=%h expected 1 %h",
                 i, if0.rd_valid, if0.rd_data, 8'(8'h11 * (i + 1)));
      end
      n_cmp++;
    end
    if (if0.underflow !== 1'b1 || if0.rd_data !== 8'h44 || if0.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_extra: unf=%b rd_data=%h rd_valid=%b expected 1 44 0",
               if0.underflow, if0.rd_data, if0.rd_valid);
    end
    n_cmp++;
  endtask

  task automatic test_fwft();
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    if (if1.rd_valid !== 1'b1 || if1.rd_data !== 8'hA5) begin
      n_err++;
      $display("FAIL fwft_visible: rd_valid=%b rd_data=%h expected 1 a5", if1.rd_valid, if1.rd_data);
    end
    n_cmp++;
    if (obs0() !== exp0()) begin
      n_err++; $display("FAIL fwft_ff0_w: got %h expected %h", obs0(), exp0());
    end
    n_cmp++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    if (if1.empty !== 1'b1 || if1.rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fwft_pop: empty=%b rd_valid=%b expected 1 0", if1.empty, if1.rd_valid);
    end
    n_cmp++;
    if (obs0() !== exp0()) begin
      n_err++; $display("FAIL fwft_ff0_r: got %h expected %h", obs0(), exp0());
    end
    n_cmp++;
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      // 10 simultaneous cycles, 2 writes to full, 1 write+read at full, 1 idle
      if (i < 10) step(1'b1, 8'(8'h03 + i), 1'b1, 1'b0);
      else if (i < 12) step(1'b1, 8'(8'h03 + i), 1'b0, 1'b0);
      else if (i == 12) step(1'b1, 8'hEE, 1'b1, 1'b0);
      else step(1'b0, 8'h00, 1'b0, 1'b0);
      if (obs0() !== exp0()) begin
        n_err++; $display("FAIL b2b_ff0[%0d]: got %h expected %h", i, obs0(), exp0());
      end
      n_cmp++;
      if (obs1() !== exp1()) begin
        n_err++; $display("FAIL b2b_ff1[%0d]: got %h expected %h", i, obs1(), exp1());
      end
      n_cmp++;
      if (i == 9 && (if0.count !== 3'd2 || if0.rd_data !== 8'h0A)) begin
        n_err++;
        $display("FAIL b2b_order: count=%0d rd_data=%h expected 2 0a", if0.count, if0.rd_data);
      end
      if (i == 9) n_cmp++;
    end
    if (if0.count !== 3'd3 || if0.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_full_rw: count=%0d ovf=%b expected 3 1", if0.count, if0.overflow);
    end
    n_cmp++;
  endtask

  task automatic test_clear();
    step(1'b1, 8'hCC, 1'b0, 1'b1);
    if (if0.count !== 3'd0 || if0.empty !== 1'b1 || if0.overflow !== 1'b0 ||
        if1.count !== 3'd0 || if1.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear_flush: count0=%0d empty0=%b ovf0=%b count1=%0d ovf1=%b expected 0 1 0 0 0",
               if0.count, if0.empty, if0.overflow, if1.count, if1.overflow);
    end
    n_cmp++;
    if (obs0() !== exp0()) begin
      n_err++; $display("FAIL clear_ff0: got %h expected %h", obs0(), exp0());
    end
    n_cmp++;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    if (if1.rd_data !== 8'h77 || if1.rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL clear_ff1_word: rd_data=%h rd_valid=%b expected 77 1", if1.rd_data, if1.rd_valid);
    end
    n_cmp++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    if (if0.rd_data !== 8'h77 || if0.rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL clear_ff0_word: rd_data=%h rd_valid=%b expected 77 1", if0.rd_data, if0.rd_valid);
    end
    n_cmp++;
  endtask

  task automatic test_random();
    int wr_pct;
    for (int i = 0; i < 400; i++) begin
      wr_pct = (i < 130) ? 75 : ((i < 260) ? 25 : 50);
      step($urandom_range(0, 99) < wr_pct, 8'($urandom), $urandom_range(0, 99) < (100 - wr_pct),
           $urandom_range(0, 59) == 0);
      if (obs0() !== exp0()) begin
        n_err++; $display("FAIL rand_ff0[%0d]: got %h expected %h", i, obs0(), exp0());
      end
      n_cmp++;
      if (obs1() !== exp1()) begin
        n_err++; $display("FAIL rand_ff1[%0d]: got %h expected %h", i, obs1(), exp1());
      end
      n_cmp++;
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b0);
    if (if0.count !== 3'd3 || if0.rd_data !== 8'h31) begin
      n_err++;
      $display("FAIL arst_pre: count=%0d rd_data=%h expected 3 31", if0.count, if0.rd_data);
    end
    n_cmp++;
    // Mid-cycle, well before the next rising edge
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    if (if0.count !== 3'd0 || if0.empty !== 1'b1 || if0.rd_valid !== 1'b0 || if0.rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL arst_now: count=%0d empty=%b rd_valid=%b rd_data=%h expected 0 1 0 00",
               if0.count, if0.empty, if0.rd_valid, if0.rd_data);
    end
    n_cmp++;
    if (obs1() !== exp1()) begin
      n_err++; $display("FAIL arst_ff1: got %h expected %h", obs1(), exp1());
    end
    n_cmp++;
    #1 rst_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    if (obs0() !== exp0()) begin
      n_err++; $display("FAIL arst_after_ff0: got %h expected %h", obs0(), exp0());
    end
    n_cmp++;
    if (obs1() !== exp1()) begin
      n_err++; $display("FAIL arst_after_ff1: got %h expected %h", obs1(), exp1());
    end
    n_cmp++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    if0.wr_en = 1'b0; if0.wr_data = '0; if0.rd_en = 1'b0;
    if1.wr_en = 1'b0; if1.wr_data = '0; if1.rd_en = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_fwft();
    test_back_to_back();
    test_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifosync_flags.md
Name: fifosync_flags

Overview:
Single-clock, parametrised FIFO. It is the next generation of the team's FIFO family, intended for same-domain buffering between pipeline stages. Relative to the existing FIFO it adds:
- a selectable first-word-fall-through read mode
- an occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a synchronous flush

Parameters:
- DW, 32, data width in bits.
- AW, 6, address width; DEPTH = 1 << AW; legal AW >= 1.
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush.
- wr_en  in  1  write request.
- wr_data  in  DW  write data.
- full  out  1  FIFO holds DEPTH words.
- almost_full  out  1  count >= AF_LEVEL.
- overflow  out  1  sticky: a write was attempted while full.
- rd_en  in  1  read request (FWFT=0) or pop/acknowledge (FWFT=1).
- rd_data  out  DW  read data.
- rd_valid  out  1  rd_data holds a valid word.
- empty  out  1  FIFO holds zero words.
- almost_empty  out  1  count <= AE_LEVEL.
- underflow  out  1  sticky: a read was attempted while empty.
- count  out  AW+1  number of stored words, 0..DEPTH.

Behaviour:
Storage and pointers
- Storage is DEPTH x DW. Read and write pointers are AW+1 bits and wrap modulo 2*DEPTH. The memory index is ptr[AW-1:0].
- count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- full = (count == DEPTH). empty = (count == 0).
- almost_full and almost_empty are compares on count. All flags are combinational from registered state. No bypass path.

Write and read acceptance
- A write is accepted iff wr_en && !full. The word is stored at wr_ptr and wr_ptr increments.
- A read is accepted iff rd_en && !empty. rd_ptr increments.
- Acceptance is evaluated against the state at the start of the cycle:
  - When full, a write is refused even if a read is accepted in the same cycle.
  - When empty, a read is refused even if a write is accepted in the same cycle.
- Simultaneous accepted read and write leave count unchanged.

FWFT=0 (registered read)
- On an accepted read, rd_data <= mem[rd_ptr] and rd_valid <= 1 on the same edge. Read latency is 1 cycle from the rd_en sample.
- rd_valid is 1 only in the cycle after an accepted read; otherwise it is 0.
- rd_data holds its last value when no read is accepted.

FWFT=1 (first-word-fall-through)
- rd_data = mem[rd_ptr] combinationally. rd_valid = !empty.
- rd_en acts as a pop. A word written at edge N is visible on rd_data after edge N, i.e. 1-cycle write-to-visible latency.

Error flags
- overflow sets on any cycle with wr_en && full.
- underflow sets on any cycle with rd_en && empty.
- Both hold until clear or reset.

Flush (clear)
- clear=1 at an edge takes priority over wr_en and rd_en: pointers <= 0, overflow <= 0, underflow <= 0, and in FWFT=0 rd_valid <= 0.
- Memory contents are not cleared. rd_data keeps its value in FWFT=0.
- Requests in the clear cycle are neither accepted nor counted as errors.

Reset
- Asserting rst_n=0 immediately forces: pointers 0, rd_data 0 (FWFT=0 register), rd_valid 0, overflow 0, underflow 0.
- Resulting outputs: empty=1, full=0, count=0, almost_empty=1, almost_full=0 (given AF_LEVEL >= 1).
- Reset mid-operation discards all contents.
- Deassertion is used as-is; the reset synchronizer is outside this block.

Elaboration checks
- Illegal parameter values cause an elaboration error.

Test Plan:
1. DW=8, AW=2, FWFT=0: reset, then write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> count 1,2,3,4; full=1 after the 4th edge; almost_full=1 from count=2 (AF_LEVEL=2). Fifth write with 0x55 -> refused, overflow=1, count stays 4.
2. Same FIFO full: read four times -> rd_data 0x11, 0x22, 0x33, 0x44, each 1 cycle after rd_en with a rd_valid pulse; empty=1. An extra rd_en -> underflow=1 and rd_data stays 0x44.
3. FWFT=1: write 0xA5 at edge N -> after edge N, rd_valid=1 and rd_data=0xA5 with no rd_en. Pop -> empty=1, rd_valid=0.
4. Count 2, wr_en and rd_en together for 10 cycles with incrementing data -> count stays 2 and output order is preserved across pointer wrap. At full, simultaneous wr_en+rd_en -> only the read is accepted, count goes to 3, overflow=1.
5. Count 3 with overflow set: pulse clear while wr_en=1 -> count=0, empty=1, overflow=0, no write stored. Then write 0x77 and read -> rd_data=0x77.
6. Count 3: assert rst_n=0 between clock edges -> count=0, empty=1, rd_valid=0, rd_data=0 immediately, before the next clock edge.
